// File: rtl/i2s_tdm_rx.sv
// Oversampled I2S/TDM receiver: synchronises bck/lrck/sdata, assembles frames, buffers them in a FWFT FIFO.
// Optional statistics counters (drop_cnt, err_cnt, stats_clr) are built when I2S_RX_STATS_EN is defined.
module i2s_tdm_rx #(
   parameter int CHANNELS   = 2,
   parameter int SLOT_W     = 32,
   parameter int DATA_W     = 24,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           enable,
   input  logic                           fmt_tdm,
   input  logic                           bck,
   input  logic                           lrck,
   input  logic                           sdata,
   output logic [CHANNELS*DATA_W-1:0]     out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
   output logic                           overflow,
   output logic                           frame_err
`ifdef I2S_RX_STATS_EN
   ,
   input  logic                           stats_clr,
   output logic [15:0]                    drop_cnt,
   output logic [15:0]                    err_cnt
`endif
);

   localparam int FRAME_W    = CHANNELS * DATA_W;
   localparam int FRAME_BITS = CHANNELS * SLOT_W;
   localparam int CNT_W      = $clog2(FRAME_BITS);
   localparam int POS_W      = $clog2(SLOT_W + 1);
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int LVL_W      = PTR_W + 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HUNT = 2'd1;
   localparam logic [1:0] RUN  = 2'd2;
   localparam logic [1:0] WAIT = 2'd3;

   logic [2:0]         in_meta_q, in_meta_d, in_sync_q, in_sync_d;
   logic               bck_prev_q, bck_prev_d, lrck_prev_q, lrck_prev_d;
   logic [1:0]         state_q, state_d;
   logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic [FRAME_W-1:0] frame_q, frame_d;
   logic               frame_err_q, frame_err_d;
   logic [FRAME_W-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]   level_q, level_d;
   logic [FRAME_W-1:0] out_data_q, out_data_d;
   logic               out_valid_q, out_valid_d;
   logic               overflow_q, overflow_d;
   logic               bck_rise, lrck_s, sdata_s, fsync;
   logic               push_req, push_ok, pop, full, drop;

   assign bck_rise = in_sync_q[2] & ~bck_prev_q;
   assign lrck_s   = in_sync_q[1];
   assign sdata_s  = in_sync_q[0];
   // I2S frames start on lrck falling; TDM frames on a one-bck high pulse.
   assign fsync    = fmt_tdm ? lrck_s : (lrck_prev_q & ~lrck_s);

   // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      in_meta_d   = {bck, lrck, sdata};
      in_sync_d   = in_meta_q;
      bck_prev_d  = in_sync_q[2];
      lrck_prev_d = bck_rise ? lrck_s : lrck_prev_q;
      state_d     = state_q;
      bitcnt_d    = bitcnt_q;
      pos_d       = pos_q;
      frame_d     = frame_q;
      frame_err_d = 1'b0;
      push_req    = 1'b0;
      if (!enable) begin
         state_d  = IDLE;
         bitcnt_d = '0;
         pos_d    = '0;
      end else begin
         case (state_q)
            IDLE: state_d = HUNT;
            HUNT, WAIT: begin
               if (bck_rise && fsync) begin
                  state_d  = RUN;
                  bitcnt_d = '0;
                  pos_d    = '0;
               end
            end
            RUN: begin
               if (bck_rise) begin
                  if (pos_q < POS_W'(DATA_W)) frame_d = {frame_q[FRAME_W-2:0], sdata_s};
                  // The last bit of a frame may share its bck edge with the next fsync.
                  if (bitcnt_q == CNT_W'(FRAME_BITS - 1)) begin
                     push_req = 1'b1;
                     state_d  = fsync ? RUN : WAIT;
                     bitcnt_d = '0;
                     pos_d    = '0;
                  end else if (fsync) begin
                     frame_err_d = 1'b1;
                     bitcnt_d    = '0;
                     pos_d       = '0;
                  end else begin
                     bitcnt_d = bitcnt_q + 1'b1;
                     pos_d    = (pos_q == POS_W'(SLOT_W - 1)) ? '0 : pos_q + 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      full        = (level_q == LVL_W'(FIFO_DEPTH));
      pop         = out_valid_q & out_ready;
      push_ok     = push_req & (~full | pop);
      drop        = push_req & full & ~pop;
      wr_ptr_d    = wr_ptr_q + PTR_W'(push_ok);
      rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
      level_d     = level_q + LVL_W'(push_ok) - LVL_W'(pop);
      overflow_d  = overflow_q | drop;
      // A frame pushed this clk becomes visible one clk later, after it lands in storage.
      out_valid_d = (level_q > LVL_W'(pop));
      out_data_d  = out_valid_d ? mem_q[rd_ptr_d] : out_data_q;
   end

   // NOTE: FIFO storage has no reset; pointers and level alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= frame_d;
   end

   // NOTE: non-blocking assignments so every flop updates from pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         in_meta_q   <= '0;
         in_sync_q   <= '0;
         bck_prev_q  <= 1'b0;
         lrck_prev_q <= 1'b0;
         state_q     <= IDLE;
         bitcnt_q    <= '0;
         pos_q       <= '0;
         frame_q     <= '0;
         frame_err_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         in_meta_q   <= in_meta_d;
         in_sync_q   <= in_sync_d;
         bck_prev_q  <= bck_prev_d;
         lrck_prev_q <= lrck_prev_d;
         state_q     <= state_d;
         bitcnt_q    <= bitcnt_d;
         pos_q       <= pos_d;
         frame_q     <= frame_d;
         frame_err_q <= frame_err_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         overflow_q  <= overflow_d;
      end
   end

   assign out_data   = out_data_q;
   assign out_valid  = out_valid_q;
   assign fifo_level = level_q;
   assign overflow   = overflow_q;
   assign frame_err  = frame_err_q;

`ifdef I2S_RX_STATS_EN
   logic [15:0] drop_cnt_q, drop_cnt_d, err_cnt_q, err_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      err_cnt_d  = err_cnt_q;
      if (stats_clr) begin
         drop_cnt_d = '0;
         err_cnt_d  = '0;
      end else begin
         if (drop && drop_cnt_q != 16'hFFFF)       drop_cnt_d = drop_cnt_q + 1'b1;
         if (frame_err_d && err_cnt_q != 16'hFFFF) err_cnt_d  = err_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         drop_cnt_q <= '0;
         err_cnt_q  <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         err_cnt_q  <= err_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
   assign err_cnt  = err_cnt_q;
`endif

endmodule

// File: tb/tb_i2s_tdm_rx.sv
// Directed bench for i2s_tdm_rx: a 2-ch I2S instance and an 8-ch TDM instance share the serial lines.
module tb_i2s_tdm_rx;

   logic         clk = 1'b0;
   logic         resetn, en0, en8, bck, lrck, sdata, rdy0, rdy8;
   logic [47:0]  od0;
   logic [191:0] od8;
   logic         ov0, ovf0, ferr0, ov8, ovf8, ferr8;
   logic [2:0]   lvl0, lvl8;
   int           vectors = 0;
   int           miscompares = 0;
   int           err0_pulses = 0;
   int           err8_pulses = 0;
   logic         pend = 1'b0;
   logic [255:0] w8;
   logic [191:0] exp8;
`ifdef I2S_RX_STATS_EN
   logic         clr;
   logic [15:0]  drop0, errc0, drop8, errc8;
`endif

   always #5 clk = ~clk;

   i2s_tdm_rx dut0 (
      .clk(clk), .resetn(resetn), .enable(en0), .fmt_tdm(1'b0),
      .bck(bck), .lrck(lrck), .sdata(sdata),
      .out_data(od0), .out_valid(ov0), .out_ready(rdy0),
      .fifo_level(lvl0), .overflow(ovf0), .frame_err(ferr0)
`ifdef I2S_RX_STATS_EN
      , .stats_clr(clr), .drop_cnt(drop0), .err_cnt(errc0)
`endif
   );

   i2s_tdm_rx #(.CHANNELS(8), .SLOT_W(32), .DATA_W(24), .FIFO_DEPTH(4)) dut8 (
      .clk(clk), .resetn(resetn), .enable(en8), .fmt_tdm(1'b1),
      .bck(bck), .lrck(lrck), .sdata(sdata),
      .out_data(od8), .out_valid(ov8), .out_ready(rdy8),
      .fifo_level(lvl8), .overflow(ovf8), .frame_err(ferr8)
`ifdef I2S_RX_STATS_EN
      , .stats_clr(clr), .drop_cnt(drop8), .err_cnt(errc8)
`endif
   );

   always @(negedge clk) begin
      if (ferr0) err0_pulses++;
      if (ferr8) err8_pulses++;
   end

   task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One bck period: low 3 clk, high 4 clk; returns on the 3rd negedge after the rise (push edge passed).
   task automatic bck_bit(input logic l, input logic d, input logic rp);
      @(negedge clk);
      bck = 1'b0; lrck = l; sdata = d;
      repeat (3) @(negedge clk);
      bck = 1'b1;
      repeat (2) @(negedge clk);
      if (rp) rdy0 = 1'b1;
      @(negedge clk);
      if (rp) rdy0 = 1'b0;
   endtask

   task automatic i2s_frame(input logic [31:0] l, input logic [31:0] r);
      logic [63:0] w;
      w = {l, r};
      bck_bit(1'b0, pend, 1'b0);
      for (int j = 0; j < 63; j++) bck_bit((j < 31) ? 1'b0 : 1'b1, w[63-j], 1'b0);
      pend = w[0];
   endtask

   task automatic i2s_partial(input int n);
      bck_bit(1'b0, pend, 1'b0);
      for (int j = 0; j < n; j++) bck_bit((j < 31) ? 1'b0 : 1'b1, 1'(j % 2), 1'b0);
      pend = 1'b0;
   endtask

   task automatic i2s_end(input logic rp);
      bck_bit(1'b1, pend, rp);
   endtask

   task automatic tdm_frame(input logic [255:0] w);
      bck_bit(1'b1, pend, 1'b0);
      for (int j = 0; j < 255; j++) bck_bit(1'b0, w[255-j], 1'b0);
      pend = w[0];
   endtask

   function automatic logic [47:0] exp_frame(input int k);
      return {8'(16 + k), 16'h0A0B, 8'(32 + k), 16'h1C1D};
   endfunction

   task automatic send_frame(input int k);
      i2s_frame({8'(16 + k), 16'h0A0B, 8'hE7}, {8'(32 + k), 16'h1C1D, 8'h3C});
   endtask

   task automatic pop0();
      @(negedge clk) rdy0 = 1'b1;
      @(negedge clk) rdy0 = 1'b0;
   endtask

   task automatic drain(input string tag, input int first, input int last);
      for (int k = first; k <= last; k++) begin
         check({tag, "_valid"}, 192'(ov0), 192'(1'b1));
         check({tag, "_data"}, 192'(od0), 192'(exp_frame(k)));
         pop0();
      end
   endtask

   task automatic lead_in();
      bck_bit(1'b1, 1'b0, 1'b0);
      bck_bit(1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      resetn = 1'b0; en0 = 1'b0; en8 = 1'b0; bck = 1'b0; lrck = 1'b1; sdata = 1'b0;
      rdy0 = 1'b0; rdy8 = 1'b0;
`ifdef I2S_RX_STATS_EN
      clr = 1'b0;
`endif
      repeat (3) @(negedge clk);
      check("rst_valid", 192'(ov0), '0);
      check("rst_level", 192'(lvl0), '0);
      check("rst_ovf", 192'(ovf0), '0);
      check("rst_ferr", 192'(ferr0), '0);
      check("rst_data", 192'(od0), '0);
      check("rst_valid8", 192'(ov8), '0);
      check("rst_data8", od8, '0);
      resetn = 1'b1;

      // TDM, 8 slots: slot n = {n, n+1, n+2, FF}; the FF byte must be discarded
      en8 = 1'b1;
      repeat (2) @(negedge clk);
      for (int n = 0; n < 8; n++) begin
         w8[255-32*n -: 32]   = {8'(n), 8'(n + 1), 8'(n + 2), 8'hFF};
         exp8[191-24*n -: 24] = {8'(n), 8'(n + 1), 8'(n + 2)};
      end
      tdm_frame(w8);
      bck_bit(1'b0, pend, 1'b0);
      check("tdm_level", 192'(lvl8), 192'(3'd1));
      @(negedge clk);
      check("tdm_valid", 192'(ov8), 192'(1'b1));
      check("tdm_data", od8, exp8);
      check("tdm_noerr", 192'(err8_pulses), '0);
      en8 = 1'b0;

      // I2S single frame and output latency
      en0 = 1'b1;
      lead_in();
      i2s_frame(32'hA5A5_5A00, 32'h1234_5600);
      i2s_end(1'b0);
      check("i2s_level_push", 192'(lvl0), 192'(3'd1));
      check("i2s_valid_early", 192'(ov0), '0);
      @(negedge clk);
      check("i2s_valid", 192'(ov0), 192'(1'b1));
      check("i2s_data", 192'(od0), 192'(48'hA5A55A_123456));
      pop0();
      check("i2s_popped", 192'(ov0), '0);
      check("i2s_empty", 192'(lvl0), '0);

      // short frame: fsync after 40 bits
      i2s_partial(40);
      send_frame(9);
      i2s_end(1'b0);
      @(negedge clk);
      check("short_err", 192'(err0_pulses), 192'(1));
      check("short_level", 192'(lvl0), 192'(3'd1));
      check("short_next", 192'(od0), 192'(exp_frame(9)));
      pop0();

      // full FIFO with push and pop in the same clk
      for (int k = 1; k <= 5; k++) send_frame(k);
      i2s_end(1'b1);
      check("pp_level", 192'(lvl0), 192'(3'd4));
      check("pp_ovf", 192'(ovf0), '0);
      drain("pp", 2, 5);
      check("pp_drained", 192'(ov0), '0);

      // overflow: six frames with no consumer
      for (int k = 1; k <= 6; k++) send_frame(k);
      i2s_end(1'b0);
      check("ovf_level", 192'(lvl0), 192'(3'd4));
      check("ovf_flag", 192'(ovf0), 192'(1'b1));
      drain("ovf", 1, 4);
      check("ovf_empty", 192'(lvl0), '0);
      check("ovf_sticky", 192'(ovf0), 192'(1'b1));
`ifdef I2S_RX_STATS_EN
      check("stat_drop", 192'(drop0), 192'(16'd2));
      check("stat_err", 192'(errc0), 192'(16'd1));
`endif

      // enable dropped mid-frame: FIFO kept, partial discarded
      send_frame(7);
      i2s_end(1'b0);
      i2s_partial(20);
      en0 = 1'b0;
      repeat (4) @(negedge clk);
      check("dis_level", 192'(lvl0), 192'(3'd1));
      check("dis_data", 192'(od0), 192'(exp_frame(7)));
      en0 = 1'b1;
      lead_in();
      send_frame(8);
      i2s_end(1'b0);
      check("dis_level2", 192'(lvl0), 192'(3'd2));
      check("dis_noerr", 192'(err0_pulses), 192'(1));
      drain("dis", 7, 8);

      // reset mid-frame with a frame stored and overflow set
      send_frame(9);
      i2s_end(1'b0);
      i2s_partial(10);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      check("rst2_valid", 192'(ov0), '0);
      check("rst2_level", 192'(lvl0), '0);
      check("rst2_ovf", 192'(ovf0), '0);
      check("rst2_data", 192'(od0), '0);
      @(negedge clk);
      resetn = 1'b1;
      lead_in();
      send_frame(10);
      i2s_end(1'b0);
      @(negedge clk);
      check("rst2_level_after", 192'(lvl0), 192'(3'd1));
      check("rst2_data_after", 192'(od0), 192'(exp_frame(10)));
      check("tdm_ovf_idle", 192'(ovf8), '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
